// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, flit type codes,
// scheduler state encoding and small index helpers.
package noc_pkg;

    localparam int NPORTS = 5;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    localparam logic [2:0] FLIT_HEAD   = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;
    localparam logic [2:0] FLIT_SINGLE = 3'b101;

    typedef enum logic {
        IDLE,
        ACTIVE
    } sched_state_t;

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p == 3'(NPORTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/output_port_scheduler_rr_pick.sv
// Round-robin picker: first set candidate at or after ptr_i,
// wrapping from the last port back to port 0.
module rr_pick
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] cand_i,
    input  logic [2:0]        ptr_i,
    output logic [NPORTS-1:0] win_o,
    output logic [2:0]        idx_o,
    output logic              found_o
);

    logic [3:0] sum;
    logic [2:0] j;
    logic       hit;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < NPORTS; k++) begin
            sum = {1'b0, ptr_i} + 4'(k);
            if (sum >= 4'(NPORTS)) begin
                sum = sum - 4'(NPORTS);
            end
            j = sum[2:0];
            if (!hit && cand_i[j]) begin
                hit      = 1'b1;
                win_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Per-output scheduler: round-robin packet lock, credit gating
// of flit forwarding and a watchdog that breaks stalled locks.
module output_port_scheduler
    import noc_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter logic [11:0] TIMEOUT = 12'd64,
    localparam int         CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [14:0]   flit_id,
    input  logic          credit_in,
    output logic [4:0]    grant,
    output logic [2:0]    xbar_sel,
    output logic [4:0]    pop,
    output logic          fwd_valid,
    output logic [CW-1:0] credits,
    output logic          timeout,
    output logic          credit_err
);

    sched_state_t      state_q, state_d;
    logic [4:0]        grant_q, grant_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [CW-1:0]     cred_q, cred_d;
    logic [11:0]       wd_q, wd_d;

    logic [NPORTS-1:0] head, tail;
    logic [NPORTS-1:0] win;
    logic [2:0]        win_idx;
    logic              found;
    logic              pop_any;

    for (genvar i = 0; i < NPORTS; i++) begin : g_type
        assign head[i] = flit_id[3*i];
        assign tail[i] = flit_id[3*i+2];
    end

    rr_pick u_pick (
        .cand_i  (req & head),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .idx_o   (win_idx),
        .found_o (found)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        pop     = '0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (found) begin
                    state_d = ACTIVE;
                    grant_d = win;
                    sel_d   = win_idx;
                end
            end
            ACTIVE: begin
                // Watchdog wins over a pop that becomes possible this cycle
                if (wd_q == TIMEOUT - 12'd1) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    ptr_d   = next_port(sel_q);
                end else if (req[sel_q] && cred_q != '0) begin
                    pop  = grant_q;
                    wd_d = '0;
                    if (tail[sel_q]) begin
                        state_d = IDLE;
                        grant_d = '0;
                        sel_d   = '0;
                        ptr_d   = next_port(sel_q);
                    end
                end else begin
                    wd_d = wd_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_any    = |pop;
        credit_err = credit_in && !pop_any && (cred_q == CW'(DEPTH));
        cred_d     = cred_q;
        if (pop_any && !credit_in) begin
            cred_d = cred_q - CW'(1);
        end else if (credit_in && !pop_any && !credit_err) begin
            cred_d = cred_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cred_q  <= CW'(DEPTH);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cred_q  <= cred_d;
            wd_q    <= wd_d;
        end
    end

    assign grant     = grant_q;
    assign xbar_sel  = sel_q;
    assign fwd_valid = pop_any;
    assign credits   = cred_q;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Self-checking bench for output_port_scheduler: vector table,
// directed corner sequences and a randomized reference-model run.
module tb_output_port_scheduler;
    import noc_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    req;
    logic [14:0]   flit_id;
    logic          credit_in;
    logic [4:0]    grant;
    logic [2:0]    xbar_sel;
    logic [4:0]    pop;
    logic          fwd_valid;
    logic [CW-1:0] credits;
    logic          timeout;
    logic          credit_err;

    output_port_scheduler #(.DEPTH(DEPTH), .TIMEOUT(12'(TMO))) dut (
        .clk(clk), .rst(rst), .req(req), .flit_id(flit_id),
        .credit_in(credit_in), .grant(grant), .xbar_sel(xbar_sel),
        .pop(pop), .fwd_valid(fwd_valid), .credits(credits),
        .timeout(timeout), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model state: owner -1 means the output is free
    int m_own, m_ptr, m_cred, m_wd;
    logic [4:0] e_grant, e_pop;
    int e_sel, e_cred, e_tmo_own;
    bit e_tmo, e_err;

    // packet sources, one per input
    int s_len[5], s_pos[5], s_stall[5];
    bit s_en[5], s_body[5];
    bit rnd_body;
    logic [4:0] drv_req;
    logic [2:0] drv_fid[5];

    // DUT values captured mid-cycle
    logic [4:0] d_grant, d_pop;
    logic [CW-1:0] d_cred;
    bit d_tmo, d_err;
    int cyc = 0;
    int d_cyc;

    function automatic logic [2:0] flit_of(input int i);
        if (s_body[i]) return FLIT_BODY;
        if (s_len[i] == 1) return FLIT_SINGLE;
        if (s_pos[i] == 0) return FLIT_HEAD;
        if (s_pos[i] == s_len[i] - 1) return FLIT_TAIL;
        if (rnd_body && ($urandom % 4 == 0)) return 3'b000;
        return FLIT_BODY;
    endfunction

    task automatic src_drive();
        for (int i = 0; i < 5; i++) begin
            drv_req[i] = s_en[i] && (s_stall[i] == 0);
            drv_fid[i] = flit_of(i);
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < 5; i++) begin
            s_en[i] = 0; s_body[i] = 0; s_pos[i] = 0;
            s_len[i] = 1; s_stall[i] = 0;
        end
        drv_req = '0;
        for (int i = 0; i < 5; i++) drv_fid[i] = FLIT_BODY;
    endtask

    task automatic src_start(input int i, input int len);
        s_en[i] = 1; s_len[i] = len; s_pos[i] = 0;
        s_body[i] = 0; s_stall[i] = 0;
    endtask

    task automatic src_advance();
        for (int i = 0; i < 5; i++) begin
            if (e_pop[i]) begin
                s_pos[i]++;
                if (s_pos[i] >= s_len[i]) s_en[i] = 0;
            end
            if (s_stall[i] > 0) s_stall[i]--;
        end
        if (e_tmo) s_en[e_tmo_own] = 0;
    endtask

    task automatic step(input bit r, input bit c);
        int nx_own, nx_ptr, nx_wd, g;
        bit p;
        rst = r;
        credit_in = c;
        req = drv_req;
        flit_id = {drv_fid[4], drv_fid[3], drv_fid[2], drv_fid[1], drv_fid[0]};
        e_pop = '0; e_tmo = 0; e_err = 0; e_tmo_own = 0;
        e_grant = (m_own < 0) ? 5'd0 : 5'(1 << m_own);
        e_sel = (m_own < 0) ? 0 : m_own;
        e_cred = m_cred;
        nx_own = m_own; nx_ptr = m_ptr; nx_wd = m_wd;
        if (m_own < 0) begin
            nx_wd = 0;
            for (int k = 0; k < 5; k++) begin
                int j;
                j = (m_ptr + k) % 5;
                if (drv_req[j] && drv_fid[j][0]) begin
                    nx_own = j;
                    break;
                end
            end
        end else begin
            g = m_own;
            if (m_wd + 1 == TMO) begin
                e_tmo = 1; e_tmo_own = g;
                nx_own = -1; nx_ptr = (g + 1) % 5;
            end else if (drv_req[g] && m_cred > 0) begin
                e_pop[g] = 1'b1;
                nx_wd = 0;
                if (drv_fid[g][2]) begin
                    nx_own = -1; nx_ptr = (g + 1) % 5;
                end
            end else begin
                nx_wd = m_wd + 1;
            end
        end
        p = |e_pop;
        e_err = c && !p && (m_cred == DEPTH);
        @(negedge clk);
        d_grant = grant; d_pop = pop; d_cred = credits;
        d_tmo = timeout; d_err = credit_err; d_cyc = cyc;
        if (!r) begin
            chk("grant", 32'(grant), 32'(e_grant));
            chk("xbar_sel", 32'(xbar_sel), 32'(e_sel));
            chk("pop", 32'(pop), 32'(e_pop));
            chk("fwd_valid", 32'(fwd_valid), 32'(p));
            chk("credits", 32'(credits), 32'(e_cred));
            chk("timeout", 32'(timeout), 32'(e_tmo));
            chk("credit_err", 32'(credit_err), 32'(e_err));
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            m_own = -1; m_ptr = 0; m_cred = DEPTH; m_wd = 0;
            e_pop = '0; e_tmo = 0;
        end else begin
            m_own = nx_own; m_ptr = nx_ptr; m_wd = nx_wd;
            m_cred = m_cred - int'(p) + int'(c && !e_err);
        end
        src_advance();
        #1;
    endtask

    task automatic do_reset();
        src_clear();
        step(1, 0);
        step(1, 0);
    endtask

    typedef struct {
        logic [4:0] rq;
        logic [2:0] fid0;
        bit         cin;
        logic [4:0] x_grant;
        logic [4:0] x_pop;
        int         x_cred;
        bit         x_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cnt, gcnt, lpops, tcnt, tcyc, lpop, nz;
        int order[$];
        int pops[5];
        bit armed, rearmed;
        logic [4:0] prev;

        tbl[0] = '{5'b00001, FLIT_SINGLE, 0, 5'b00000, 5'b00000, DEPTH,     0};
        tbl[1] = '{5'b00001, FLIT_SINGLE, 0, 5'b00001, 5'b00001, DEPTH,     0};
        tbl[2] = '{5'b00000, FLIT_BODY,   0, 5'b00000, 5'b00000, DEPTH - 1, 0};
        tbl[3] = '{5'b00000, FLIT_BODY,   1, 5'b00000, 5'b00000, DEPTH - 1, 0};
        tbl[4] = '{5'b00000, FLIT_BODY,   1, 5'b00000, 5'b00000, DEPTH,     1};
        tbl[5] = '{5'b00000, FLIT_BODY,   0, 5'b00000, 5'b00000, DEPTH,     0};

        rnd_body = 0;
        m_own = -1; m_ptr = 0; m_cred = DEPTH; m_wd = 0;
        rst = 1; req = '0; flit_id = '0; credit_in = 0;
        @(posedge clk);
        #1;
        do_reset();

        // single-flit packet and idle credit overflow
        for (int v = 0; v < 6; v++) begin
            drv_req = tbl[v].rq;
            drv_fid[0] = tbl[v].fid0;
            for (int i = 1; i < 5; i++) drv_fid[i] = FLIT_BODY;
            step(0, tbl[v].cin);
            chk("vec_grant", 32'(d_grant), 32'(tbl[v].x_grant));
            chk("vec_pop", 32'(d_pop), 32'(tbl[v].x_pop));
            chk("vec_credits", 32'(d_cred), 32'(tbl[v].x_cred));
            chk("vec_credit_err", 32'(d_err), 32'(tbl[v].x_err));
        end

        // round-robin over five 3-flit packets, L comes back last
        do_reset();
        for (int i = 0; i < 5; i++) begin
            src_start(i, 3);
            pops[i] = 0;
        end
        gcnt = 0; lpops = 0; rearmed = 0; prev = '0;
        for (int k = 0; k < 80 && gcnt < 6; k++) begin
            src_drive();
            step(0, 1);
            if (d_grant != 0 && prev == 0) begin
                for (int i = 0; i < 5; i++) if (d_grant[i]) order.push_back(i);
                gcnt++;
            end
            prev = d_grant;
            for (int i = 0; i < 5; i++) if (d_pop[i] && gcnt < 6) pops[i]++;
            if (!s_en[0] && !rearmed) begin
                src_start(0, 3);
                rearmed = 1;
            end
        end
        chk("rr_grants", 32'(gcnt), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(i % 5));
        end
        for (int i = 0; i < 5; i++) chk("rr_pops", 32'(pops[i]), 32'd3);

        // credit stall with a 6-flit packet
        do_reset();
        src_start(0, 6);
        cnt = 0;
        for (int k = 0; k < 7; k++) begin
            src_drive();
            step(0, 0);
            if (d_pop[0]) cnt++;
        end
        chk("stall_pops", 32'(cnt), 32'd4);
        chk("stall_credits", 32'(d_cred), 32'd0);
        src_drive();
        step(0, 1);
        chk("stall_cin_cycle", 32'(d_pop), 32'd0);
        src_drive();
        step(0, 0);
        chk("stall_one_more", 32'(d_pop), 32'd1);
        src_drive();
        step(0, 0);
        chk("stall_after", 32'(d_pop), 32'd0);

        // simultaneous pop and credit return
        do_reset();
        src_start(0, 20);
        src_drive();
        step(0, 0);
        for (int k = 0; k < 10; k++) begin
            src_drive();
            step(0, 1);
            chk("popcin_credits", 32'(d_cred), 32'(DEPTH));
            chk("popcin_pop", 32'(d_pop), 32'd1);
        end

        // watchdog: owner vanishes after its head
        do_reset();
        src_start(0, 3);
        src_drive();
        step(0, 0);
        src_drive();
        step(0, 0);
        lpop = d_pop[0] ? d_cyc : -1;
        s_en[0] = 0;
        tcnt = 0; tcyc = -1; armed = 0;
        for (int k = 0; k < 14; k++) begin
            if (tcyc >= 0 && !armed) begin
                src_start(0, 1);
                src_start(1, 1);
                armed = 1;
            end
            src_drive();
            step(0, 0);
            if (d_tmo) begin
                tcnt++;
                if (tcyc < 0) begin
                    tcyc = d_cyc;
                    chk("wd_delay", 32'(d_cyc - lpop), 32'(TMO));
                end
            end
            if (tcyc < 0 && d_pop != 0) lpop = d_cyc;
            if (tcyc >= 0 && d_cyc == tcyc + 1) chk("wd_grant_clear", 32'(d_grant), 32'd0);
            if (tcyc >= 0 && d_cyc == tcyc + 2) chk("wd_next_grant", 32'(d_grant), 32'b00010);
        end
        chk("wd_pulses", 32'(tcnt), 32'd1);

        // reset in the middle of a packet
        do_reset();
        src_start(0, 5);
        for (int k = 0; k < 3; k++) begin
            src_drive();
            step(0, 0);
        end
        src_drive();
        step(1, 0);
        s_en[0] = 1;
        s_body[0] = 1;
        src_drive();
        step(0, 0);
        chk("rst_grant", 32'(d_grant), 32'd0);
        chk("rst_pop", 32'(d_pop), 32'd0);
        chk("rst_credits", 32'(d_cred), 32'(DEPTH));
        chk("rst_timeout", 32'(d_tmo), 32'd0);
        nz = 0;
        for (int k = 0; k < 20; k++) begin
            src_drive();
            step(0, 0);
            if (d_grant != 0) nz++;
        end
        chk("body_never_granted", 32'(nz), 32'd0);

        // randomized traffic against the model
        do_reset();
        rnd_body = 1;
        for (int k = 0; k < 3000; k++) begin
            bit r;
            for (int i = 0; i < 5; i++) begin
                if (!s_en[i] && ($urandom % 8 == 0)) src_start(i, $urandom_range(1, 4));
                if (s_en[i] && s_stall[i] == 0 && ($urandom % 48 == 0))
                    s_stall[i] = $urandom_range(1, 12);
            end
            r = ($urandom % 500 == 0);
            src_drive();
            step(r, (k < 1500) ? ($urandom % 3 == 0) : ($urandom % 2 == 0));
            if (r) src_clear();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
